// File: rtl/packet_header_builder.sv
// packet_header_builder
//   Serializes one framed packet header per request onto a 32-bit bus:
//   marker word, Ethernet (14 B), IPv4 (20 B), then an optional TCP (20 B)
//   or UDP (8 B) header. Bytes are big-endian (first byte in bus[31:24]).
//   The last word always carries two bytes (bus_keep = 4'b1100).
//
// Optional feature: define IPV4_CSUM_EN to compute the IPv4 header checksum
//   in a CSUM state (one 16-bit word per cycle, 10 cycles). Otherwise ip_csum
//   is inserted verbatim.
//
// Ports
//   CLK, reset             clock, synchronous active-high reset
//   req_valid / req_ready  request handshake; ready only in IDLE
//   dest_mac .. payload_len header field inputs, latched on acceptance
//   bus, bus_valid, bus_ready, bus_last, bus_keep   output word stream
//   busy                   a request is in progress
module packet_header_builder #(
  parameter logic [31:0] MARKER = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [7:0]  ip_tos,
  input  logic [7:0]  ip_ttl,
  input  logic [7:0]  ip_proto,
  input  logic [15:0] ip_id,
  input  logic [15:0] ip_csum,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [31:0] tcp_seq,
  input  logic [31:0] tcp_ack,
  input  logic [11:0] tcp_flags,
  input  logic [15:0] tcp_window,
  input  logic [15:0] l4_csum,
  input  logic [15:0] payload_len,
  output logic [31:0] bus,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_last,
  output logic [3:0]  bus_keep,
  output logic        busy
);

`ifdef IPV4_CSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_SEND} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

  state_t       state_q, state_d;
  logic [479:0] buf_q, buf_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   last_q, last_d;
  logic         valid_q, valid_d;

  // Header assembly from the live inputs; only used on the accept cycle.
  logic [15:0]  l4_len, total_len, udp_len, csum_field;
  logic [159:0] l4_hdr;
  logic [3:0]   last_idx;
  logic [479:0] new_buf;

`ifdef IPV4_CSUM_EN
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] hw;
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        unused_csum;
  assign unused_csum = ^ip_csum;
  assign csum_field  = 16'h0000;  // summed as zero, patched in CSUM
`else
  assign csum_field  = ip_csum;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    l4_len   = 16'd0;
    l4_hdr   = '0;
    last_idx = 4'd9;
    udp_len  = 16'd8 + payload_len;
    case (ip_proto)
      8'h06: begin
        l4_len   = 16'd20;
        l4_hdr   = {src_port, dst_port, tcp_seq, tcp_ack, 4'h5, tcp_flags,
                    tcp_window, l4_csum, 16'h0000};
        last_idx = 4'd14;
      end
      8'h11: begin
        l4_len   = 16'd8;
        l4_hdr   = {src_port, dst_port, udp_len, l4_csum, 96'h0};
        last_idx = 4'd11;
      end
      default: ;
    endcase
    total_len = 16'd20 + l4_len + payload_len;  // wraps mod 2^16
    new_buf   = {MARKER, dest_mac, src_mac, 16'h0800, 8'h45, ip_tos,
                 total_len, ip_id, 16'h4000, ip_ttl, ip_proto, csum_field,
                 src_ip, dst_ip, l4_hdr, 16'h0000};
  end

`ifdef IPV4_CSUM_EN
  // IPv4 header starts at byte 18 of the buffer (after marker + Ethernet).
  always_comb begin
    hw = 16'h0000;
    for (int i = 0; i < 10; i++)
      if (cnt_q == i[3:0]) hw = buf_q[335-16*i -: 16];
    sum   = acc_q + {4'h0, hw};
    fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
  end
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef IPV4_CSUM_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (req_valid) begin
          buf_d  = new_buf;
          last_d = last_idx;
          idx_d  = 4'd0;
`ifdef IPV4_CSUM_EN
          acc_d   = 20'h0;
          cnt_d   = 4'd0;
          state_d = S_CSUM;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef IPV4_CSUM_EN
      S_CSUM: begin
        acc_d = sum;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          buf_d[255:240] = ~fold2;
          state_d        = S_SEND;
        end
      end
`endif
      S_SEND: begin
        // One prefill cycle raises bus_valid; the index then moves per handshake.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus_ready) begin
          if (idx_q == last_q) begin
            valid_d = 1'b0;
            idx_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      last_q  <= 4'd0;
      valid_q <= 1'b0;
`ifdef IPV4_CSUM_EN
      acc_q   <= 20'h0;
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef IPV4_CSUM_EN
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // NOTE: the byte buffer is deliberately not reset; its contents only reach
  // the bus while valid_q is set, and every request rewrites it.
  always_ff @(posedge CLK) begin
    buf_q <= buf_d;
  end

  logic [31:0] word;
  always_comb begin
    word = 32'h0;
    for (int i = 0; i < 15; i++)
      if (idx_q == i[3:0]) word = buf_q[479-32*i -: 32];
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign bus_valid = valid_q;
  assign bus       = valid_q ? word : 32'h0;
  assign bus_last  = valid_q && (idx_q == last_q);
  assign bus_keep  = !valid_q ? 4'b0000 : (bus_last ? 4'b1100 : 4'b1111);

endmodule

// File: tb/tb_packet_header_builder.sv
// Directed self-checking bench for packet_header_builder. Three fixed
// requests (UDP, TCP, other protocol) with hand-computed word images.
module tb_packet_header_builder;

  logic        CLK = 1'b0;
  logic        reset, req_valid, req_ready;
  logic [47:0] dest_mac, src_mac;
  logic [7:0]  ip_tos, ip_ttl, ip_proto;
  logic [15:0] ip_id, ip_csum;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port;
  logic [31:0] tcp_seq, tcp_ack;
  logic [11:0] tcp_flags;
  logic [15:0] tcp_window, l4_csum, payload_len;
  logic [31:0] bus;
  logic        bus_valid, bus_ready, bus_last, busy;
  logic [3:0]  bus_keep;

  always #5 CLK = ~CLK;

  packet_header_builder dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .dest_mac(dest_mac), .src_mac(src_mac), .ip_tos(ip_tos), .ip_ttl(ip_ttl),
    .ip_proto(ip_proto), .ip_id(ip_id), .ip_csum(ip_csum), .src_ip(src_ip),
    .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .tcp_seq(tcp_seq), .tcp_ack(tcp_ack), .tcp_flags(tcp_flags),
    .tcp_window(tcp_window), .l4_csum(l4_csum), .payload_len(payload_len),
    .bus(bus), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_last(bus_last), .bus_keep(bus_keep), .busy(busy)
  );

`ifdef IPV4_CSUM_EN
  localparam int          LAT     = 11;
  localparam logic [31:0] UDP_W7  = 32'hB861C0A8;
  localparam logic [31:0] TCP_W7  = 32'h26260A00;
  localparam logic [31:0] OTH_W7  = 32'h57A30102;
`else
  localparam int          LAT     = 1;
  localparam logic [31:0] UDP_W7  = 32'h1111C0A8;
  localparam logic [31:0] TCP_W7  = 32'h22220A00;
  localparam logic [31:0] OTH_W7  = 32'h33330102;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          got;
  logic [31:0] got_w [16];
  logic [3:0]  got_k [16];
  logic        got_l [16];
  logic [31:0] exp_w [16];
  logic [31:0] exp_udp [12];
  logic [31:0] exp_tcp [15];
  logic [31:0] exp_oth [10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = UDP, 1 = TCP, 2 = protocol 01 (no L4 header)
  task automatic set_req(input int sel);
    case (sel)
      0: begin
        dest_mac = 48'h001122334455; src_mac = 48'h66778899AABB;
        ip_tos = 8'h00; ip_ttl = 8'h40; ip_proto = 8'h11; ip_id = 16'h0000;
        ip_csum = 16'h1111; src_ip = 32'hC0A80001; dst_ip = 32'hC0A800C7;
        src_port = 16'h1234; dst_port = 16'h5678; tcp_seq = 32'hFFFFFFFF;
        tcp_ack = 32'hEEEEEEEE; tcp_flags = 12'hFFF; tcp_window = 16'h9999;
        l4_csum = 16'hABCD; payload_len = 16'd87;
      end
      1: begin
        dest_mac = 48'hAABBCCDDEEFF; src_mac = 48'h102030405060;
        ip_tos = 8'hB8; ip_ttl = 8'h80; ip_proto = 8'h06; ip_id = 16'hBEEF;
        ip_csum = 16'h2222; src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
        src_port = 16'h0050; dst_port = 16'hC350; tcp_seq = 32'h01020304;
        tcp_ack = 32'hA0B0C0D0; tcp_flags = 12'h018; tcp_window = 16'hFFFF;
        l4_csum = 16'h5A5A; payload_len = 16'h0100;
      end
      default: begin
        dest_mac = 48'h010203040506; src_mac = 48'h0708090A0B0C;
        ip_tos = 8'h00; ip_ttl = 8'h01; ip_proto = 8'h01; ip_id = 16'h1234;
        ip_csum = 16'h3333; src_ip = 32'h01020304; dst_ip = 32'h05060708;
        src_port = 16'hFFFF; dst_port = 16'hFFFF; tcp_seq = 32'hFFFFFFFF;
        tcp_ack = 32'hFFFFFFFF; tcp_flags = 12'hFFF; tcp_window = 16'hFFFF;
        l4_csum = 16'hFFFF; payload_len = 16'hFFFF;  // totalLength wraps to 0x0013
      end
    endcase
  endtask

  // Present a request for one cycle and measure the latency to bus_valid.
  task automatic send_req(input int sel);
    int lat = 0;
    @(negedge CLK);
    set_req(sel);
    check("ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", req_ready, 0);
    check("valid_at_accept", bus_valid, 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (bus_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, LAT);
  endtask

  // Accept n beats; with toggle, bus_ready alternates 0/1 starting at 0.
  task automatic collect(input int n, input bit toggle);
    int          cyc = 0;
    bit          phase = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held_w;
    logic [3:0]  held_k;
    logic        held_l;
    got = 0;
    while (got < n && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      check("ready_low_in_pkt", req_ready, 0);
      if (!bus_valid) begin
        if (got > 0 || stalled) check("valid_held", bus_valid, 1);
      end else begin
        if (stalled) begin
          check("hold_bus", bus, held_w);
          check("hold_keep", bus_keep, held_k);
          check("hold_last", bus_last, held_l);
          stalled = 1'b0;
        end
        bus_ready = toggle ? phase : 1'b1;
        phase = ~phase;
        if (bus_ready) begin
          got_w[got] = bus;
          got_k[got] = bus_keep;
          got_l[got] = bus_last;
          got++;
        end else begin
          held_w  = bus;
          held_k  = bus_keep;
          held_l  = bus_last;
          stalled = 1'b1;
        end
      end
    end
    check("beats", got, n);
  endtask

  task automatic check_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("word%0d", i), got_w[i], exp_w[i]);
      check($sformatf("keep%0d", i), got_k[i], (i == n - 1) ? 32'hC : 32'hF);
      check($sformatf("last%0d", i), got_l[i], (i == n - 1) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bus_valid"}, bus_valid, 0);
    check({tag, "_bus"}, bus, 0);
    check({tag, "_bus_keep"}, bus_keep, 0);
    check({tag, "_bus_last"}, bus_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_udp = '{32'hDEADBEEF, 32'h00112233, 32'h44556677, 32'h8899AABB,
                32'h08004500, 32'h00730000, 32'h40004011, 32'h0,
                32'h0001C0A8, 32'h00C71234, 32'h5678005F, 32'hABCD0000};
    exp_udp[7] = UDP_W7;
    exp_tcp = '{32'hDEADBEEF, 32'hAABBCCDD, 32'hEEFF1020, 32'h30405060,
                32'h080045B8, 32'h0128BEEF, 32'h40008006, 32'h0,
                32'h00010A00, 32'h00020050, 32'hC3500102, 32'h0304A0B0,
                32'hC0D05018, 32'hFFFF5A5A, 32'h00000000};
    exp_tcp[7] = TCP_W7;
    exp_oth = '{32'hDEADBEEF, 32'h01020304, 32'h05060708, 32'h090A0B0C,
                32'h08004500, 32'h00131234, 32'h40000101, 32'h0,
                32'h03040506, 32'h07080000};
    exp_oth[7] = OTH_W7;

    // Reset and idle
    reset = 1'b1; req_valid = 1'b0; bus_ready = 1'b0;
    set_req(0);
    repeat (3) @(posedge CLK);
    #1 idle_check("in_reset");
    @(negedge CLK) reset = 1'b0;
    repeat (5) @(negedge CLK);
    idle_check("idle5");

    // UDP, full rate
    send_req(0);
    collect(12, 1'b0);
    @(posedge CLK); #1;
    idle_check("udp_done");
    @(negedge CLK) bus_ready = 1'b0;
    for (int i = 0; i < 12; i++) exp_w[i] = exp_udp[i];
    check_pkt(12);

    // TCP with alternating backpressure
    send_req(1);
    collect(15, 1'b1);
    @(posedge CLK); #1;
    idle_check("tcp_done");
    @(negedge CLK) bus_ready = 1'b0;
    for (int i = 0; i < 15; i++) exp_w[i] = exp_tcp[i];
    check_pkt(15);
    check("tcp_data_offset", {28'h0, got_w[12][15:12]}, 32'h5);

    // Other protocol; a second request and new field values mid-packet
    send_req(2);
    @(negedge CLK);
    set_req(1);
    req_valid = 1'b1;
    collect(10, 1'b0);
    req_valid = 1'b0;
    @(posedge CLK); #1;
    idle_check("oth_done");
    @(negedge CLK) bus_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("no_queued_valid", bus_valid, 0);
      check("no_queued_busy", busy, 0);
    end
    for (int i = 0; i < 10; i++) exp_w[i] = exp_oth[i];
    check_pkt(10);

    // Reset after the third handshake of a TCP packet
    send_req(1);
    collect(3, 1'b0);
    for (int i = 0; i < 3; i++)
      check($sformatf("pre_reset_word%0d", i), got_w[i], exp_tcp[i]);
    @(posedge CLK);
    @(negedge CLK);
    check("word3_before_reset", bus, 32'h30405060);
    reset = 1'b1;
    bus_ready = 1'b0;
    @(posedge CLK); #1;
    idle_check("after_reset");
    @(negedge CLK) reset = 1'b0;
    send_req(0);
    collect(12, 1'b0);
    @(posedge CLK); #1;
    idle_check("post_reset_done");
    @(negedge CLK) bus_ready = 1'b0;
    for (int i = 0; i < 12; i++) exp_w[i] = exp_udp[i];
    check_pkt(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
